fifo_level: RTL and testbench

- Parametrised synchronous FIFO that generalises the existing 8-bit FIFO.
- Adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags, a synchronous clear, and a first-word-fall-through (FWFT) read mode.
- Sits between bus-side producers and consumers: UART TX/RX buffering and the memory-controller command queue.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_mem.sv | 25 ++
 rtl/fifo_level.sv | 119 +++++++++++
 tb/tb_fifo_level.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the fifo_level FIFO and its storage array.
package fifo_pkg;

  // Ceiling log2, used for pointer and occupancy widths at elaboration.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [clog2(DEPTH)-1:0]   i_wr_addr,
  input  logic [WIDTH-1:0]          i_wr_data,
  input  logic [clog2(DEPTH)-1:0]   i_rd_addr,
  output logic [WIDTH-1:0]          o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_level.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags, synchronous clear and optional FWFT read.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr,
  input  logic [FIFO_WIDTH-1:0]        input_data,
  input  logic                         rd,
  output logic [FIFO_WIDTH-1:0]        output_data,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [clog2(FIFO_DEPTH):0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int ADDR_W = clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0]  AEMPTY_C = CNT_W'(AEMPTY_THRESH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  generate
    if (FIFO_WIDTH < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_params
      $fatal(1, "fifo_level: illegal parameter combination");
    end
  endgenerate

  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [FIFO_WIDTH-1:0] w_rd_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_rd_ok = rd & ~w_empty;
  // A read on a full FIFO frees the slot the same-cycle write lands in.
  assign w_wr_ok = wr & (~w_full | w_rd_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_wr_ok && !w_rd_ok)      r_count <= r_count + CNT_ONE;
      else if (w_rd_ok && !w_wr_ok) r_count <= r_count - CNT_ONE;
      if (wr && !w_wr_ok) r_overflow  <= 1'b1;
      if (rd && !w_rd_ok) r_underflow <= 1'b1;
    end
  end

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_wr_ok & ~clr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (input_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  generate
    if (FWFT == 0) begin : g_reg_out
      logic [FIFO_WIDTH-1:0] r_out;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_out <= '0;
        else if (clr)     r_out <= '0;
        else if (w_rd_ok) r_out <= w_rd_data;
      end
      assign output_data = r_out;
    end else begin : g_fwft_out
      assign output_data = w_rd_data;
    end
  endgenerate

  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= AEMPTY_C);
  assign almost_full  = (r_count >= AFULL_C);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_level.sv
// Self-checking bench for fifo_level: registered-read instance plus an FWFT instance.
module tb_fifo_level;

  logic       clk;
  logic       rst;
  logic       clr0, wr0, rd0;
  logic [7:0] din0, dout0;
  logic       empty0, full0, ae0, af0, ovf0, unf0;
  logic [3:0] count0;
  logic       clr1, wr1, rd1;
  logic [7:0] din1, dout1;
  logic       empty1, full1, ae1, af1, ovf1, unf1;
  logic [3:0] count1;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: accepted write data queued at drive time, popped when read data appears.
  logic [7:0] exp_q[$];
  int         m_cnt;
  logic       m_ovf, m_unf;

  fifo_level #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr0), .wr(wr0), .input_data(din0), .rd(rd0),
    .output_data(dout0), .empty(empty0), .full(full0), .almost_empty(ae0),
    .almost_full(af0), .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_level #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr1), .wr(wr1), .input_data(din1), .rd(rd1),
    .output_data(dout1), .empty(empty1), .full(full1), .almost_empty(ae1),
    .almost_full(af1), .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle on dut0, update the reference model, sample 1 time unit after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic rd_ok, wr_ok;
    wr0 = w; din0 = d; rd0 = r; clr0 = c;
    rd_ok = r && (m_cnt != 0);
    wr_ok = w && ((m_cnt != 8) || rd_ok);
    if (c) begin
      m_cnt = 0; exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (wr_ok) exp_q.push_back(d);
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && !rd_ok) m_unf = 1'b1;
      m_cnt = m_cnt + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
    end
    @(posedge clk); #1;
    wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
  endtask

  task automatic step1(input logic w, input logic [7:0] d, input logic r);
    wr1 = w; din1 = d; rd1 = r;
    @(posedge clk); #1;
    wr1 = 1'b0; rd1 = 1'b0;
  endtask

  task automatic model_reset();
    m_cnt = 0; exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++; if (count0 !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count0); end
    n_checks++; if ({empty0, full0, ae0, af0} !== 4'b1010) begin n_fail++; $display("FAIL reset_flags: got %b want 1010", {empty0, full0, ae0, af0}); end
    n_checks++; if ({ovf0, unf0} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {ovf0, unf0}); end
    n_checks++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout0); end
    n_checks++; if ({empty1, count1} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL reset_fwft: got empty=%b count=%0d want 1/0", empty1, count1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] exp;
    step(1'b1, 8'h67, 1'b0, 1'b0);
    n_checks++; if (count0 !== 4'(m_cnt) || m_cnt != 1) begin n_fail++; $display("FAIL single_cnt1: got %0d want 1", count0); end
    n_checks++; if (empty0 !== 1'b0) begin n_fail++; $display("FAIL single_empty0: got %b want 0", empty0); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    n_checks++; if (dout0 !== exp) begin n_fail++; $display("FAIL single_data: got %h want %h", dout0, exp); end
    n_checks++; if (count0 !== 4'd0 || empty0 !== 1'b1) begin n_fail++; $display("FAIL single_drain: got count=%0d empty=%b want 0/1", count0, empty0); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] exp;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      n_checks++; if (count0 !== 4'(i)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", count0, i); end
      n_checks++; if (af0 !== (i >= 6)) begin n_fail++; $display("FAIL fill_afull: count %0d got %b want %b", i, af0, (i >= 6)); end
      n_checks++; if (ae0 !== (i <= 2)) begin n_fail++; $display("FAIL fill_aempty: count %0d got %b want %b", i, ae0, (i <= 2)); end
    end
    n_checks++; if (full0 !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full0); end
    step(1'b1, 8'h09, 1'b0, 1'b0);
    n_checks++; if (ovf0 !== m_ovf || !m_ovf) begin n_fail++; $display("FAIL fill_overflow: got %b want 1", ovf0); end
    n_checks++; if (count0 !== 4'd8) begin n_fail++; $display("FAIL fill_ovf_count: got %0d want 8", count0); end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++; if (dout0 !== exp || exp !== 8'(i)) begin n_fail++; $display("FAIL fill_read: got %h want %h", dout0, 8'(i)); end
    end
    n_checks++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %b want 1", empty0); end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hAA, 1'b1, 1'b0);
      exp = exp_q.pop_front();
      n_checks++; if (dout0 !== exp) begin n_fail++; $display("FAIL fullrw_data: got %h want %h", dout0, exp); end
      n_checks++; if ({count0, full0, ovf0} !== {4'd8, 1'b1, 1'b0}) begin n_fail++; $display("FAIL fullrw_state: got count=%0d full=%b ovf=%b want 8/1/0", count0, full0, ovf0); end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      exp = exp_q.pop_front();
      n_checks++; if (dout0 !== exp) begin n_fail++; $display("FAIL fullrw_drain: got %h want %h", dout0, exp); end
    end
    n_checks++; if ({empty0, unf0} !== 2'b10) begin n_fail++; $display("FAIL fullrw_end: got empty=%b unf=%b want 1/0", empty0, unf0); end
  endtask

  task automatic test_underflow();
    logic [7:0] exp;
    step(1'b1, 8'h4D, 1'b1, 1'b0);
    n_checks++; if (unf0 !== m_unf || !m_unf) begin n_fail++; $display("FAIL unf_flag: got %b want 1", unf0); end
    n_checks++; if (count0 !== 4'd1) begin n_fail++; $display("FAIL unf_count: got %0d want 1", count0); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    n_checks++; if (dout0 !== exp || exp !== 8'h4D) begin n_fail++; $display("FAIL unf_data: got %h want 4d", dout0); end
  endtask

  task automatic test_fwft();
    step1(1'b1, 8'hEF, 1'b0);
    n_checks++; if ({empty1, dout1} !== {1'b0, 8'hEF}) begin n_fail++; $display("FAIL fwft_head: got empty=%b data=%h want 0/ef", empty1, dout1); end
    step1(1'b1, 8'h02, 1'b0);
    n_checks++; if (dout1 !== 8'hEF || count1 !== 4'd2) begin n_fail++; $display("FAIL fwft_hold: got data=%h count=%0d want ef/2", dout1, count1); end
    step1(1'b0, 8'h00, 1'b1);
    n_checks++; if (dout1 !== 8'h02 || count1 !== 4'd1) begin n_fail++; $display("FAIL fwft_next: got data=%h count=%0d want 02/1", dout1, count1); end
    step1(1'b0, 8'h00, 1'b1);
    n_checks++; if (empty1 !== 1'b1) begin n_fail++; $display("FAIL fwft_empty: got %b want 1", empty1); end
  endtask

  task automatic test_clr();
    logic [7:0] exp;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      exp = exp_q.pop_front();
      n_checks++; if (dout0 !== exp) begin n_fail++; $display("FAIL clr_pre_read: got %h want %h", dout0, exp); end
    end
    n_checks++; if ({count0, ovf0} !== {4'd5, 1'b1}) begin n_fail++; $display("FAIL clr_setup: got count=%0d ovf=%b want 5/1", count0, ovf0); end
    step(1'b1, 8'h99, 1'b0, 1'b1);
    n_checks++; if ({count0, empty0, ovf0} !== {4'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL clr_state: got count=%0d empty=%b ovf=%b want 0/1/0", count0, empty0, ovf0); end
    n_checks++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL clr_dout: got %h want 00", dout0); end
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    n_checks++; if (dout0 !== exp || exp !== 8'h11) begin n_fail++; $display("FAIL clr_after: got %h want 11", dout0); end
  endtask

  task automatic test_async_rst();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    wr0 = 1'b1; din0 = 8'h3F;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if ({count0, empty0} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL arst_immediate: got count=%0d empty=%b want 0/1", count0, empty0); end
    wr0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    n_checks++; if (dout0 !== exp || exp !== 8'h5A) begin n_fail++; $display("FAIL arst_after: got %h want 5a", dout0); end
  endtask

  initial begin
    rst = 1'b1;
    clr0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0; din0 = 8'h00;
    clr1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0; din1 = 8'h00;
    model_reset();
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_rw();
    test_underflow();
    test_fwft();
    test_clr();
    test_async_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
